// File: rtl/spi_frame_tx.sv
// SPI mode-0 frame transmitter for the PmodCLS: sends a byte-packed frame MSB-byte-first,
// stopping at the frame end or the first NULL byte, and pulses end_transmission when done.
module spi_frame_tx #(
  parameter int FRAME_BITS = 152,
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] data_in,
  input  logic                  begin_transmission,
  input  logic                  slave_select,
  output logic                  end_transmission,
  output logic                  busy,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi
);

  localparam int NBYTES = FRAME_BITS / 8;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int BYTE_W = $clog2(NBYTES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BYTE_W-1:0] BYTE_END = BYTE_W'(NBYTES);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] GAP   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]            state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [7:0]            tx_byte;
  logic [2:0]            bit_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [BYTE_W-1:0]     byte_cnt;
  logic [7:0]            top_byte;

  assign top_byte = shift_reg[FRAME_BITS-1 -: 8];

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      // NOTE: the frame buffer is cleared too, so nothing from an interrupted frame
      // can leak into the next one; it is a plain register, not a RAM.
      shift_reg        <= '0;
      tx_byte          <= '0;
      bit_cnt          <= '0;
      div_cnt          <= '0;
      gap_cnt          <= '0;
      byte_cnt         <= '0;
      end_transmission <= 1'b0;
      busy             <= 1'b0;
      cs_n             <= 1'b1;
      sclk             <= 1'b0;
      mosi             <= 1'b0;
    end else begin
      end_transmission <= 1'b0;
      if (state != IDLE && slave_select) begin
        // Abort: drop the link immediately and return silently to IDLE.
        state    <= IDLE;
        busy     <= 1'b0;
        cs_n     <= 1'b1;
        sclk     <= 1'b0;
        mosi     <= 1'b0;
        bit_cnt  <= '0;
        div_cnt  <= '0;
        gap_cnt  <= '0;
        byte_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (begin_transmission && !slave_select) begin
              shift_reg <= data_in;
              byte_cnt  <= '0;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
          LOAD: begin
            if (byte_cnt == BYTE_END || top_byte == 8'h00) begin
              state <= DONE;
            end else begin
              cs_n    <= 1'b0;
              mosi    <= top_byte[7];
              tx_byte <= {top_byte[6:0], 1'b0};
              bit_cnt <= '0;
              div_cnt <= '0;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              sclk    <= ~sclk;
              // Falling edge: present the next bit; the 8th fall closes the byte.
              if (sclk) begin
                mosi    <= tx_byte[7];
                tx_byte <= {tx_byte[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  gap_cnt <= '0;
                  state   <= GAP;
                end
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt   <= '0;
              shift_reg <= shift_reg << 8;
              byte_cnt  <= byte_cnt + 1'b1;
              state     <= LOAD;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          DONE: begin
            cs_n             <= 1'b1;
            end_transmission <= 1'b1;
            busy             <= 1'b0;
            state            <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: stimulus queues expected bytes, SPI monitors decode
// mosi on SCLK rises and compare; frame timing is checked against hand-derived counts.
module tb_spi_frame_tx;

  localparam int CD     = 2;
  localparam int GC     = 4;
  localparam int BYTE_T = 16 * CD + GC + 1;  // clk cycles per sent byte (37)

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  din_s = '0;
  logic         beg_s = 1'b0;
  logic         ss_s  = 1'b0;
  logic         end_s, busy_s, cs_s, sclk_s, mosi_s;
  logic [151:0] din_l = '0;
  logic         beg_l = 1'b0;
  logic         ss_l  = 1'b0;
  logic         end_l, busy_l, cs_l, sclk_l, mosi_l;

  spi_frame_tx #(.FRAME_BITS(32), .CLK_DIV(CD), .GAP_CYCLES(GC)) dut_s (
    .clk(clk), .rst(rst), .data_in(din_s), .begin_transmission(beg_s),
    .slave_select(ss_s), .end_transmission(end_s), .busy(busy_s),
    .cs_n(cs_s), .sclk(sclk_s), .mosi(mosi_s)
  );

  spi_frame_tx dut_l (
    .clk(clk), .rst(rst), .data_in(din_l), .begin_transmission(beg_l),
    .slave_select(ss_l), .end_transmission(end_l), .busy(busy_l),
    .cs_n(cs_l), .sclk(sclk_l), .mosi(mosi_l)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0] q_s[$];
  logic [7:0] q_l[$];

  // Monitor for the small instance: byte decode, SCLK spacing and frame event times.
  int         t0_s = 0;
  logic       ps_sclk = 1'b0, ps_cs = 1'b1, ps_end = 1'b0;
  logic [7:0] rx_s = '0;
  int         bits_s = 0, rises_s = 0, falls_s = 0, end_cnt_s = 0;
  int         end_rel_s = 0, cs_low_rel_s = 0, first_rise_rel_s = 0, last_rise_s = 0;
  bit         fresh_s = 1'b1;

  always @(negedge clk) begin
    if (sclk_s && !ps_sclk) begin
      check("sclk_rise_cs_n", {31'd0, cs_s}, 32'd0);
      rises_s++;
      if (fresh_s) begin
        first_rise_rel_s = cyc - t0_s;
        fresh_s = 1'b0;
      end else begin
        check("sclk_spacing", cyc - last_rise_s, (bits_s == 0) ? BYTE_T - 14 * CD : 2 * CD);
      end
      last_rise_s = cyc;
      rx_s = {rx_s[6:0], mosi_s};
      bits_s++;
      if (bits_s == 8) begin
        bits_s = 0;
        if (q_s.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL byte_s: got %02h, expected no byte", rx_s);
        end else begin
          check("byte_s", {24'd0, rx_s}, {24'd0, q_s.pop_front()});
        end
      end
    end
    if (cs_s) begin
      bits_s  = 0;
      fresh_s = 1'b1;
    end
    if (!cs_s && ps_cs) begin
      falls_s++;
      cs_low_rel_s = cyc - t0_s;
    end
    if (end_s) begin
      check("end_pulse_width", {31'd0, ps_end}, 32'd0);
      if (!ps_end) begin
        end_cnt_s++;
        end_rel_s = cyc - t0_s;
      end
    end
    ps_sclk = sclk_s;
    ps_cs   = cs_s;
    ps_end  = end_s;
  end

  // Monitor for the default-parameter instance.
  int         t0_l = 0;
  logic       pl_sclk = 1'b0, pl_end = 1'b0;
  logic [7:0] rx_l = '0;
  int         bits_l = 0, end_cnt_l = 0, end_rel_l = 0;

  always @(negedge clk) begin
    if (sclk_l && !pl_sclk) begin
      check("sclk_rise_cs_n_l", {31'd0, cs_l}, 32'd0);
      rx_l = {rx_l[6:0], mosi_l};
      bits_l++;
      if (bits_l == 8) begin
        bits_l = 0;
        if (q_l.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL byte_l: got %02h, expected no byte", rx_l);
        end else begin
          check("byte_l", {24'd0, rx_l}, {24'd0, q_l.pop_front()});
        end
      end
    end
    if (cs_l) bits_l = 0;
    if (end_l && !pl_end) begin
      end_cnt_l++;
      end_rel_l = cyc - t0_l;
    end
    pl_sclk = sclk_l;
    pl_end  = end_l;
  end

  task automatic start_s(input logic [31:0] d);
    @(negedge clk);
    din_s = d;
    t0_s  = cyc;
    beg_s = 1'b1;
    @(negedge clk);
    beg_s = 1'b0;
    din_s = 32'hFFFF_FFFF;  // must not disturb the latched frame
  endtask

  task automatic wait_end_s(input int prev, input int budget, input string name);
    int n = 0;
    while (end_cnt_s == prev && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, end_cnt_s - prev, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_end"},  {31'd0, end_s},  32'd0);
    check({tag, "_busy"}, {31'd0, busy_s}, 32'd0);
    check({tag, "_cs_n"}, {31'd0, cs_s},   32'd1);
    check({tag, "_sclk"}, {31'd0, sclk_s}, 32'd0);
    check({tag, "_mosi"}, {31'd0, mosi_s}, 32'd0);
  endtask

  initial begin
    int prev, pr, pf, n;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: NULL terminates after three bytes; data_in changes after the latch.
    prev = end_cnt_s;
    pr   = rises_s;
    q_s.push_back(8'h1B); q_s.push_back(8'h5B); q_s.push_back(8'h6A);
    start_s(32'h1B5B6A00);
    wait_end_s(prev, 300, "t1_end_seen");
    check("t1_end_rel", end_rel_s, 3 * BYTE_T + 3);
    check("t1_cs_low_rel", cs_low_rel_s, 32'd2);
    check("t1_first_rise_rel", first_rise_rel_s, 2 + CD);
    check("t1_rises", rises_s - pr, 32'd24);
    check("t1_cs_n_after", {31'd0, cs_s}, 32'd1);
    check("t1_busy_after", {31'd0, busy_s}, 32'd0);
    check("t1_queue_empty", q_s.size(), 32'd0);

    // T2: full frame limited by byte count.
    prev = end_cnt_s;
    pr   = rises_s;
    q_s.push_back(8'h41); q_s.push_back(8'h42); q_s.push_back(8'h43); q_s.push_back(8'h44);
    start_s(32'h41424344);
    wait_end_s(prev, 300, "t2_end_seen");
    check("t2_end_rel", end_rel_s, 4 * BYTE_T + 3);
    check("t2_rises", rises_s - pr, 32'd32);
    check("t2_queue_empty", q_s.size(), 32'd0);

    // T3: empty frame, no link activity.
    prev = end_cnt_s;
    pr   = rises_s;
    pf   = falls_s;
    start_s(32'h00FFFFFF);
    wait_end_s(prev, 20, "t3_end_seen");
    check("t3_end_rel", end_rel_s, 32'd3);
    check("t3_rises", rises_s - pr, 32'd0);
    check("t3_cs_falls", falls_s - pf, 32'd0);

    // T4: begin ignored while slave_select=1, then abort during byte 2.
    @(negedge clk);
    ss_s  = 1'b1;
    beg_s = 1'b1;
    @(negedge clk);
    beg_s = 1'b0;
    @(negedge clk);
    check("t4_ss_blocks_begin", {31'd0, busy_s}, 32'd0);
    ss_s = 1'b0;
    prev = end_cnt_s;
    q_s.push_back(8'h41);
    start_s(32'h41424344);
    repeat (49) @(negedge clk);
    ss_s = 1'b1;
    @(negedge clk);
    check_idle_outputs("t4_abort");
    repeat (50) @(negedge clk);
    check("t4_no_end", end_cnt_s - prev, 32'd0);
    check("t4_queue_empty", q_s.size(), 32'd0);
    ss_s = 1'b0;
    prev = end_cnt_s;
    q_s.push_back(8'h41); q_s.push_back(8'h42); q_s.push_back(8'h43); q_s.push_back(8'h44);
    start_s(32'h41424344);
    wait_end_s(prev, 300, "t4_restart_end_seen");
    check("t4_restart_end_rel", end_rel_s, 4 * BYTE_T + 3);
    check("t4_restart_queue_empty", q_s.size(), 32'd0);

    // T5: reset mid-SHIFT wins over a simultaneous begin.
    prev = end_cnt_s;
    start_s(32'h41424344);
    repeat (9) @(negedge clk);
    rst   = 1'b1;
    beg_s = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_rst");
    rst   = 1'b0;
    beg_s = 1'b0;
    @(negedge clk);
    check("t5_idle_after_rst", {31'd0, busy_s}, 32'd0);
    check("t5_no_end", end_cnt_s - prev, 32'd0);

    // T5b: begin held high throughout the frame only triggers once.
    prev = end_cnt_s;
    q_s.push_back(8'h55);
    @(negedge clk);
    t0_s  = cyc;
    din_s = 32'h55000000;
    beg_s = 1'b1;
    n = 0;
    while (!end_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    beg_s = 1'b0;
    check("t5_hold_end_seen", {31'd0, end_s}, 32'd1);
    repeat (20) @(negedge clk);
    check("t5_hold_end_count", end_cnt_s - prev, 32'd1);
    check("t5_hold_end_rel", end_rel_s, BYTE_T + 3);
    check("t5_hold_busy", {31'd0, busy_s}, 32'd0);
    check("t5_hold_queue_empty", q_s.size(), 32'd0);

    // T6: default parameters, 18 bytes before the NULL.
    prev = end_cnt_l;
    q_l.push_back(8'h1B); q_l.push_back(8'h5B); q_l.push_back(8'h6A);
    q_l.push_back(8'h31); q_l.push_back(8'h32); q_l.push_back(8'h33); q_l.push_back(8'h34);
    repeat (11) q_l.push_back(8'h20);
    @(negedge clk);
    t0_l  = cyc;
    din_l = 152'h1B5B6A31323334_2020202020202020202020_00;
    beg_l = 1'b1;
    @(negedge clk);
    beg_l = 1'b0;
    n = 0;
    while (end_cnt_l == prev && n < 60000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("t6_end_seen", end_cnt_l - prev, 32'd1);
    check("t6_end_rel", end_rel_l, 18 * (16 * 50 + 2000 + 1) + 3);
    check("t6_queue_empty", q_l.size(), 32'd0);
    check("t6_cs_n_after", {31'd0, cs_l}, 32'd1);
    repeat (10) @(negedge clk);
    check("t6_single_end", end_cnt_l - prev, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
